// File: rtl/imem_pkg.sv
// Shared types for the instruction/data memory arbiter: default widths,
// response owner encoding and the per-slot response tag.
package imem_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rsp_tag_t;

  localparam rsp_tag_t TAG_NONE = '{valid: 1'b0, owner: OWN_IF};

endpackage

// File: rtl/imem_rsp_pipe.sv
// Purpose: RD_LAT-deep shift register of response tags, one slot per issued command.
// Latency: a tag entering on tag_in appears on tag_out exactly RD_LAT cycles later.
// Backpressure: none; advances every cycle, async reset drops all in-flight tags.
module imem_rsp_pipe
  import imem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  rsp_tag_t tag_in,
  output rsp_tag_t tag_out
);

  rsp_tag_t pipe [RD_LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= TAG_NONE;
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tag_out = pipe[RD_LAT-1];

endmodule

// File: rtl/imem_arbiter.sv
// Purpose: shares one single-port memory between fetch and load/store; optional
// fetch starvation guard under IMEM_ARB_STARVE_GUARD_EN. Latency: grant is
// combinational, rvalid exactly RD_LAT cycles later. Backpressure: req held until gnt.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (RD_LAT < 1 || RD_LAT > 4 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_param
    $error("imem_arbiter: RD_LAT or STARVE_MAX out of range");
  end

  logic     force_if;
  rsp_tag_t tag_in;
  rsp_tag_t tag_out;

`ifdef IMEM_ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= 4'd0;
    end else if (if_req && !if_gnt) begin
      if (starve_cnt != 4'(STARVE_MAX)) starve_cnt <= starve_cnt + 4'd1;
    end else begin
      starve_cnt <= 4'd0;
    end
  end

  assign force_if = (starve_cnt == 4'(STARVE_MAX));
`else
  assign force_if = 1'b0;
`endif

  // Grants are gated by rst so every output reads 0 the moment reset asserts.
  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (rst) begin
      if (ls_req && !(if_req && force_if)) ls_gnt = 1'b1;
      else if (if_req)                     if_gnt = 1'b1;
    end
  end

  always_comb begin
    mem_en    = if_gnt | ls_gnt;
    mem_we    = ls_gnt & ls_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ls_gnt) begin
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
    end
  end

  always_comb begin
    tag_in.valid = mem_en & ~mem_we;
    tag_in.owner = ls_gnt ? OWN_LS : OWN_IF;
  end

  imem_rsp_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rsp_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign if_rvalid = tag_out.valid && (tag_out.owner == OWN_IF);
  assign ls_rvalid = tag_out.valid && (tag_out.owner == OWN_LS);
  assign if_rdata  = rst ? mem_rdata : '0;
  assign ls_rdata  = rst ? mem_rdata : '0;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: three instances (RD_LAT 1..3) share stimulus, each with its own memory.
module tb_imem_arbiter;

  localparam int SM = 4;
`ifdef IMEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [7:0]  if_addr = 8'h00;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [7:0]  ls_addr = 8'h00;
  logic [15:0] ls_wdata = 16'h0000;

  logic [2:0]  if_gnt_w, if_rvalid_w, ls_gnt_w, ls_rvalid_w, mem_en_w, mem_we_w;
  logic [7:0]  mem_addr_w  [3];
  logic [15:0] mem_wdata_w [3];
  logic [15:0] if_rdata_w  [3];
  logic [15:0] ls_rdata_w  [3];
  logic [15:0] mem_rdata_w [3];

  logic [15:0] env_mem [3][256];
  logic [15:0] rp      [3][4];
  logic        loaded = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    imem_arbiter #(
      .ADDR_W(8), .DATA_W(16), .RD_LAT(k + 1), .STARVE_MAX(SM)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt_w[k]),
      .if_rvalid (if_rvalid_w[k]),
      .if_rdata  (if_rdata_w[k]),
      .ls_req    (ls_req),
      .ls_we     (ls_we),
      .ls_addr   (ls_addr),
      .ls_wdata  (ls_wdata),
      .ls_gnt    (ls_gnt_w[k]),
      .ls_rvalid (ls_rvalid_w[k]),
      .ls_rdata  (ls_rdata_w[k]),
      .mem_en    (mem_en_w[k]),
      .mem_we    (mem_we_w[k]),
      .mem_addr  (mem_addr_w[k]),
      .mem_wdata (mem_wdata_w[k]),
      .mem_rdata (mem_rdata_w[k])
    );
    assign mem_rdata_w[k] = rp[k][k];
  end

  function automatic logic [15:0] init_val(input int i);
    if (i == 16) return 16'hABCD;
    return 16'h5A00 ^ 16'(i);
  endfunction

  // Memory macro per instance: synchronous, read data delayed RD_LAT cycles.
  always @(posedge clk) begin
    if (!loaded) begin
      for (int k = 0; k < 3; k++)
        for (int i = 0; i < 256; i++) env_mem[k][i] <= init_val(i);
      loaded <= 1'b1;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (mem_en_w[k] && mem_we_w[k]) env_mem[k][mem_addr_w[k]] <= mem_wdata_w[k];
        if (mem_en_w[k] && !mem_we_w[k]) rp[k][0] <= env_mem[k][mem_addr_w[k]];
        else rp[k][0] <= 16'h0000;
        for (int j = 1; j < 4; j++) rp[k][j] <= rp[k][j-1];
      end
    end
  end

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %h expected %h", name, k, act, exp);
    end
  endtask

  // Reference model: list of issued reads with their issue cycle, owner and data.
  typedef struct {
    int          cyc;
    bit          own_ls;
    logic [15:0] data;
  } issue_t;

  issue_t      hist[$];
  logic [15:0] ref_mem [256];
  bit          ref_init = 1'b0;
  int          cyc = 0;
  int          starve = 0;

  always @(negedge clk) begin
    bit          e_if, e_ls, e_en, e_we, f_if, f_ls;
    logic [7:0]  e_addr;
    logic [15:0] e_wd, f_d;
    if (!ref_init) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
      ref_init = 1'b1;
    end
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        check("rst_if_gnt", k, if_gnt_w[k], 0);
        check("rst_ls_gnt", k, ls_gnt_w[k], 0);
        check("rst_mem_en", k, mem_en_w[k], 0);
        check("rst_mem_we", k, mem_we_w[k], 0);
        check("rst_mem_addr", k, mem_addr_w[k], 0);
        check("rst_mem_wdata", k, mem_wdata_w[k], 0);
        check("rst_if_rvalid", k, if_rvalid_w[k], 0);
        check("rst_ls_rvalid", k, ls_rvalid_w[k], 0);
        check("rst_if_rdata", k, if_rdata_w[k], 0);
        check("rst_ls_rdata", k, ls_rdata_w[k], 0);
      end
      hist.delete();
      starve = 0;
    end else begin
      if (if_req && ls_req) begin
        e_if = GUARD && (starve == SM);
        e_ls = !e_if;
      end else begin
        e_if = if_req;
        e_ls = ls_req;
      end
      e_en   = e_if || e_ls;
      e_we   = e_ls && ls_we;
      e_addr = e_ls ? ls_addr : (e_if ? if_addr : 8'h00);
      e_wd   = e_ls ? ls_wdata : 16'h0000;
      for (int k = 0; k < 3; k++) begin
        check("if_gnt", k, if_gnt_w[k], e_if);
        check("ls_gnt", k, ls_gnt_w[k], e_ls);
        check("mem_en", k, mem_en_w[k], e_en);
        check("mem_we", k, mem_we_w[k], e_we);
        check("mem_addr", k, mem_addr_w[k], e_addr);
        check("mem_wdata", k, mem_wdata_w[k], e_wd);
        f_if = 1'b0;
        f_ls = 1'b0;
        f_d  = 16'h0000;
        foreach (hist[j]) begin
          if (hist[j].cyc + k + 1 == cyc) begin
            f_ls = hist[j].own_ls;
            f_if = !hist[j].own_ls;
            f_d  = hist[j].data;
          end
        end
        check("if_rvalid", k, if_rvalid_w[k], f_if);
        check("ls_rvalid", k, ls_rvalid_w[k], f_ls);
        if (f_if) check("if_rdata", k, if_rdata_w[k], f_d);
        if (f_ls) check("ls_rdata", k, ls_rdata_w[k], f_d);
      end
      if (e_en && !e_we) hist.push_back('{cyc: cyc, own_ls: e_ls, data: ref_mem[e_addr]});
      if (e_en && e_we) ref_mem[e_addr] = e_wd;
      if (if_req && !e_if) starve = (starve < SM) ? starve + 1 : SM;
      else starve = 0;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] pat;
    int         n;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    tick();
    rst = 1'b1;
    tick();

    // Fetch only from 0x10.
    if_req = 1'b1; if_addr = 8'h10;
    @(negedge clk);
    check("a_if_gnt", 0, if_gnt_w[0], 1);
    check("a_mem_en", 0, mem_en_w[0], 1);
    check("a_mem_we", 0, mem_we_w[0], 0);
    tick();
    if_req = 1'b0;
    @(negedge clk);
    check("a_if_rvalid", 0, if_rvalid_w[0], 1);
    check("a_if_rdata", 0, if_rdata_w[0], 16'hABCD);
    check("a_ls_rvalid", 0, ls_rvalid_w[0], 0);
    repeat (4) tick();

    // Store and fetch to the same address together: store first, fetch sees new data.
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 8'h10; ls_wdata = 16'h1234;
    if_req = 1'b1; if_addr = 8'h10;
    @(negedge clk);
    check("b_ls_gnt", 0, ls_gnt_w[0], 1);
    check("b_if_gnt", 0, if_gnt_w[0], 0);
    tick();
    ls_req = 1'b0; ls_we = 1'b0;
    @(negedge clk);
    check("b_if_gnt_late", 0, if_gnt_w[0], 1);
    tick();
    if_req = 1'b0;
    @(negedge clk);
    check("b_if_rvalid", 0, if_rvalid_w[0], 1);
    check("b_if_rdata", 0, if_rdata_w[0], 16'h1234);
    repeat (4) tick();

    // Both requesters held for ten cycles.
    if_req = 1'b1; if_addr = 8'h30;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h20;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      pat[i] = if_gnt_w[0];
      tick();
    end
    check("c_if_pattern", 0, pat, GUARD ? 10'b1000010000 : 10'b0000000000);
    ls_req = 1'b0;
    @(negedge clk);
    check("c_if_alone", 0, if_gnt_w[0], 1);
    tick();
    if_req = 1'b0;
    repeat (4) tick();

    // Alternating owners, checked on the RD_LAT=3 instance.
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h01;
    tick();
    ls_req = 1'b0; if_req = 1'b1; if_addr = 8'h02;
    tick();
    if_req = 1'b0; ls_req = 1'b1; ls_addr = 8'h03;
    tick();
    ls_req = 1'b0;
    @(negedge clk);
    check("d_ls_rvalid_1", 2, ls_rvalid_w[2], 1);
    check("d_ls_rdata_1", 2, ls_rdata_w[2], 16'h5A01);
    tick();
    @(negedge clk);
    check("d_if_rvalid_2", 2, if_rvalid_w[2], 1);
    check("d_if_rdata_2", 2, if_rdata_w[2], 16'h5A02);
    tick();
    @(negedge clk);
    check("d_ls_rvalid_3", 2, ls_rvalid_w[2], 1);
    check("d_ls_rdata_3", 2, ls_rdata_w[2], 16'h5A03);
    repeat (4) tick();

    // Top address: write, read back by ls, then fetch.
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 8'hFF; ls_wdata = 16'hBEEF;
    tick();
    ls_we = 1'b0;
    tick();
    ls_req = 1'b0; if_req = 1'b1; if_addr = 8'hFF;
    tick();
    if_req = 1'b0;
    @(negedge clk);
    check("e_if_rdata", 0, if_rdata_w[0], 16'hBEEF);
    repeat (4) tick();

    // Reset with a read in flight.
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h05;
    tick();
    ls_req = 1'b0; if_req = 1'b1; if_addr = 8'h40;
    #1 rst = 1'b0;
    #1;
    check("f_if_gnt_now", 1, if_gnt_w[1], 0);
    check("f_mem_en_now", 1, mem_en_w[1], 0);
    check("f_ls_rvalid_now", 0, ls_rvalid_w[0], 0);
    @(negedge clk);
    tick();
    rst = 1'b1; if_req = 1'b0;
    n = 0;
    repeat (4) begin
      @(negedge clk);
      n += $countones(ls_rvalid_w);
    end
    check("f_no_stale_rvalid", 1, n, 0);
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
